data_mem_responder: RTL and testbench

//  Data-memory target for the RV32I core's load/store port. Accepts one request at a time
//  (byte address, write data, funct3) and answers after a programmable wait.

---
 rtl/data_mem_responder_pkg.sv | 61 ++++++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_load_extend.sv | 32 +++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Funct3 codes, FSM states, alignment/legality/lane decode.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_t;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    case (funct3[1:0])
      2'b01:   r = off[0];
      2'b10:   r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(
    input logic       we,
    input logic [2:0] funct3
  );
    logic r;
    if (we) begin
      r = (funct3 >= 3'b011);
    end else begin
      r = (funct3 == 3'b011) ||
          (funct3 == 3'b110) ||
          (funct3 == 3'b111);
    end
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    case (funct3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the
// datapath data port (master) and the memory (slave).
interface data_mem_responder_if;

  logic        iReq;
  logic        iWrEn;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic [31:0] oRdData;
  logic        oAck;
  logic        oErr;
  logic        oBusy;

  modport master (
    output iReq, iWrEn, iFunct3, iAddr, iWrData,
    input  oRdData, oAck, oErr, oBusy
  );

  modport slave (
    input  iReq, iWrEn, iFunct3, iAddr, iWrData,
    output oRdData, oAck, oErr, oBusy
  );

endinterface

// File: rtl/data_mem_responder_load_extend.sv
// Selects the addressed byte/half of a word and
// sign- or zero-extends it according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? word_i[31:16]
                             : word_i[15:0];

  // Extend the selected lane; unknown codes give zero
  always_comb begin
    data_o = 32'h0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store memory with a
// programmable wait between accept and commit.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input logic                 iClk,
  input logic                 iRst,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AW    = ADDR_W + 2;

  mem_state_t     state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wd_q;
  logic [31:0]    rdata_q;
  logic           err_q;

  logic [3:0][7:0] mem_q [DEPTH];

  logic           accept;
  logic           commit;
  logic           cur_we;
  logic [2:0]     cur_f3;
  logic [AW-1:0]  cur_addr;
  logic [31:0]    cur_wd;
  logic [ADDR_W-1:0] idx;
  logic [1:0]     off;
  logic           bad;
  logic [3:0]     be;
  logic [31:0]    wlanes;
  logic [31:0]    rd_word;
  logic [31:0]    ext;
  logic           unused_addr;

  assign unused_addr = ^bus.iAddr[31:AW];

  assign accept = (state_q == ST_IDLE) && bus.iReq;
  assign commit = (state_q != ST_RESP) &&
                  (state_d == ST_RESP);

  // Next-state and wait-counter decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iReq) begin
          cnt_d = 3'(LATENCY);
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait the commit happens on the accept
  // edge, so the live inputs stand in for the regs
  always_comb begin
    cur_we   = we_q;
    cur_f3   = f3_q;
    cur_addr = addr_q;
    cur_wd   = wd_q;
    if (state_q == ST_IDLE) begin
      cur_we   = bus.iWrEn;
      cur_f3   = bus.iFunct3;
      cur_addr = bus.iAddr[AW-1:0];
      cur_wd   = bus.iWrData;
    end
  end

  assign idx = cur_addr[AW-1:2];
  assign off = cur_addr[1:0];
  assign bad = is_misaligned(cur_f3, off) ||
               is_illegal(cur_we, cur_f3);
  assign be  = (cur_we && !bad) ?
               lane_mask(cur_f3, off) : 4'b0000;

  // Replicate store data so each lane sees its bits
  always_comb begin
    wlanes = cur_wd;
    case (cur_f3[1:0])
      2'b00:   wlanes = {4{cur_wd[7:0]}};
      2'b01:   wlanes = {2{cur_wd[15:0]}};
      default: wlanes = cur_wd;
    endcase
  end

  assign rd_word = mem_q[idx];

  load_extend u_ext (
    .word_i   (rd_word),
    .off_i    (off),
    .funct3_i (cur_f3),
    .data_o   (ext)
  );

  // State, counter and response registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q   <= bad;
        rdata_q <= (cur_we || bad) ? 32'h0 : ext;
      end
    end
  end

  // Request capture on accept
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      we_q   <= 1'b0;
      f3_q   <= 3'b000;
      addr_q <= '0;
      wd_q   <= 32'h0;
    end else if (accept) begin
      we_q   <= bus.iWrEn;
      f3_q   <= bus.iFunct3;
      addr_q <= bus.iAddr[AW-1:0];
      wd_q   <= bus.iWrData;
    end
  end

  // Byte-lane RAM write on the commit edge
  always_ff @(posedge iClk) begin
    if (commit && !iRst) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem_q[idx][l] <= wlanes[8*l +: 8];
        end
      end
    end
  end

  assign bus.oAck    = (state_q == ST_RESP);
  assign bus.oBusy   = (state_q != ST_IDLE);
  assign bus.oRdData = rdata_q;
  assign bus.oErr    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (wait 2 and 0)
// against a byte-array reference model.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mem_m [int];

  always #5 clk = ~clk;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut0 (
    .iClk (clk),
    .iRst (rst0),
    .bus  (bus0)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(0)) dut1 (
    .iClk (clk),
    .iRst (rst1),
    .bus  (bus1)
  );

  // Reference: byte-addressed memory, size from funct3,
  // alignment by modulo, extension by bit replication
  function automatic exp_t model(
    input int          inst,
    input bit          we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd
  );
    exp_t e;
    int a;
    int size;
    bit bad;
    logic [31:0] v;
    a = int'(addr[9:0]);
    case (f3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      2'b10:   size = 4;
      default: size = 0;
    endcase
    if (size == 0) bad = 1'b1;
    else if ((a % size) != 0) bad = 1'b1;
    else if (we) bad = f3[2];
    else bad = (f3 == 3'b110);
    e.err = bad;
    e.rd  = 32'h0;
    if (!bad) begin
      if (we) begin
        for (int i = 0; i < size; i++)
          mem_m[inst*4096 + a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++)
          v[8*i +: 8] = mem_m[inst*4096 + a + i];
        if (!f3[2])
          for (int b = 8*size; b < 32; b++)
            v[b] = v[8*size-1];
        e.rd = v;
      end
    end
    return e;
  endfunction

  task automatic drive(
    input int          inst,
    input logic        req,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd
  );
    if (inst == 0) begin
      bus0.iReq = req; bus0.iWrEn = we;
      bus0.iFunct3 = f3; bus0.iAddr = addr;
      bus0.iWrData = wd;
    end else begin
      bus1.iReq = req; bus1.iWrEn = we;
      bus1.iFunct3 = f3; bus1.iAddr = addr;
      bus1.iWrData = wd;
    end
  endtask

  task automatic set_req(input int inst, input logic v);
    if (inst == 0) bus0.iReq = v;
    else bus1.iReq = v;
  endtask

  function automatic logic ack_of(input int inst);
    return (inst == 0) ? bus0.oAck : bus1.oAck;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? bus0.oBusy : bus1.oBusy;
  endfunction

  // Issue one access, push its expected response,
  // then watch latency and busy until the ack
  task automatic issue(
    input int          inst,
    input bit          we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input int          exp_lat,
    input bit          repulse
  );
    exp_t e;
    int n;
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    e = model(inst, we, f3, addr, wd);
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
    drive(inst, 1'b1, we, f3, addr, wd);
    @(posedge clk); #1;
    set_req(inst, 1'b0);
    n = 1;
    while (!ack_of(inst) && n < 20) begin
      if (!busy_of(inst)) busy_ok = 1'b0;
      if (repulse && n == 1) set_req(inst, 1'b1);
      @(posedge clk); #1;
      set_req(inst, 1'b0);
      n++;
    end
    if (!busy_of(inst)) busy_ok = 1'b0;
    checks++;
    if (!ack_of(inst)) begin
      errors++;
      $display("FAIL ack_timeout inst%0d: got none, need ack in %0d",
               inst, exp_lat);
    end
    if (exp_lat > 0) begin
      checks++;
      if (n != exp_lat) begin
        errors++;
        $display("FAIL latency inst%0d: got %0d need %0d",
                 inst, n, exp_lat);
      end
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL busy inst%0d: got low, need high to ack",
               inst);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare each ack against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (bus0.oAck) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack0: got ack, need none");
      end else begin
        e = q0.pop_front();
        if (bus0.oRdData !== e.rd || bus0.oErr !== e.err) begin
          errors++;
          $display("FAIL resp0: got %h/%b need %h/%b",
                   bus0.oRdData, bus0.oErr, e.rd, e.err);
        end
      end
    end
    if (bus1.oAck) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack1: got ack, need none");
      end else begin
        e = q1.pop_front();
        if (bus1.oRdData !== e.rd || bus1.oErr !== e.err) begin
          errors++;
          $display("FAIL resp1: got %h/%b need %h/%b",
                   bus1.oRdData, bus1.oErr, e.rd, e.err);
        end
      end
    end
  end

  task automatic check_idle0(input string name);
    checks++;
    if (bus0.oAck !== 1'b0 || bus0.oErr !== 1'b0 ||
        bus0.oBusy !== 1'b0 || bus0.oRdData !== 32'h0) begin
      errors++;
      $display("FAIL %s: got ack%b err%b busy%b rd%h need all 0",
               name, bus0.oAck, bus0.oErr, bus0.oBusy,
               bus0.oRdData);
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle0("reset0");
    checks++;
    if (bus1.oAck !== 1'b0 || bus1.oBusy !== 1'b0 ||
        bus1.oRdData !== 32'h0 || bus1.oErr !== 1'b0) begin
      errors++;
      $display("FAIL reset1: got ack%b busy%b need 0",
               bus1.oAck, bus1.oBusy);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;

    for (int w = 0; w < 16; w++)
      issue(0, 1, 3'b010, 32'(4*w), $urandom, 3, 0);

    // Word store/load round trip
    issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 0);
    issue(0, 0, 3'b010, 32'h10, 32'h0, 3, 0);
    // Byte lanes, sign and zero extension
    issue(0, 1, 3'b000, 32'h13, 32'h80, 3, 0);
    issue(0, 0, 3'b000, 32'h13, 32'h0, 3, 0);
    issue(0, 0, 3'b100, 32'h13, 32'h0, 3, 0);
    issue(0, 0, 3'b010, 32'h10, 32'h0, 3, 0);
    // Upper halfword
    issue(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 3, 0);
    issue(0, 0, 3'b001, 32'h22, 32'h0, 3, 0);
    issue(0, 0, 3'b101, 32'h20, 32'h0, 3, 0);
    issue(0, 0, 3'b010, 32'h20, 32'h0, 3, 0);
    // Error cases leave memory untouched
    issue(0, 0, 3'b010, 32'h11, 32'h0, 3, 0);
    issue(0, 1, 3'b001, 32'h21, 32'h5555AAAA, 3, 0);
    issue(0, 0, 3'b011, 32'h10, 32'h0, 3, 0);
    issue(0, 1, 3'b011, 32'h24, 32'h11111111, 3, 0);
    issue(0, 1, 3'b100, 32'h24, 32'h22222222, 3, 0);
    issue(0, 0, 3'b110, 32'h24, 32'h0, 3, 0);
    issue(0, 0, 3'b010, 32'h20, 32'h0, 3, 0);
    issue(0, 0, 3'b010, 32'h24, 32'h0, 3, 0);
    // Upper address bits alias
    issue(0, 0, 3'b010, 32'hFFFF_FC10, 32'h0, 3, 0);

    // Re-request during the wait is dropped
    issue(0, 0, 3'b010, 32'h10, 32'h0, 3, 1);
    repeat (6) @(posedge clk);

    // Reset during the wait of a store
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
    @(posedge clk); #1;
    set_req(0, 1'b0);
    @(posedge clk); #2;
    rst0 = 1'b1;
    #1;
    check_idle0("async_reset");
    @(posedge clk); #1;
    rst0 = 1'b0;
    repeat (6) @(posedge clk);
    issue(0, 0, 3'b010, 32'h30, 32'h0, 3, 0);

    // Random traffic over the initialised region
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'hFFFF_FC00) |
           32'($urandom_range(0, 63));
      issue(0, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ra, $urandom, 3, 0);
    end

    // Zero-wait instance: ack on the cycle after accept
    issue(1, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 0);
    issue(1, 0, 3'b010, 32'h10, 32'h0, 1, 0);
    issue(1, 1, 3'b000, 32'h13, 32'h80, 1, 0);
    issue(1, 0, 3'b000, 32'h13, 32'h0, 1, 0);

    repeat (4) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d pending need 0/0",
               q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
